// File: rtl/eth_phy_10g_rx_aligner.sv
// 66-bit block aligner: selects a 66-bit window out of two consecutive raw SERDES words
// at a bit offset stepped by edge-detected, holdoff-filtered bitslip requests.
module eth_phy_10g_rx_aligner #(
  parameter bit          BIT_REVERSE  = 1'b0,
  parameter bit          INPUT_REG    = 1'b0,
  parameter int unsigned SLIP_HOLDOFF = 16,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [65:0]            serdes_rx_raw,
  input  logic                   serdes_rx_bitslip,
  output logic [63:0]            serdes_rx_data,
  output logic [1:0]             serdes_rx_hdr,
  output logic [6:0]             slip_offset,
  output logic                   slip_wrap,
  output logic [COUNT_WIDTH-1:0] slip_count
);

  localparam int unsigned       HOLD_W      = (SLIP_HOLDOFF < 2) ? 1 : $clog2(SLIP_HOLDOFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(SLIP_HOLDOFF);
  localparam logic [6:0]        LAST_OFFSET = 7'd65;

  logic [65:0] raw_ord;
  logic [65:0] raw_word;

  generate
    if (BIT_REVERSE) begin : g_rev
      always_comb begin
        raw_ord = '0;
        for (int i = 0; i < 66; i++) begin
          raw_ord[i] = serdes_rx_raw[65-i];
        end
      end
    end else begin : g_norev
      assign raw_ord = serdes_rx_raw;
    end

    if (INPUT_REG) begin : g_in_reg
      logic [65:0] in_reg_q;
      logic [65:0] in_reg_d;

      assign in_reg_d = raw_ord;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_reg_q <= '0;
        end else begin
          in_reg_q <= in_reg_d;
        end
      end

      assign raw_word = in_reg_q;
    end else begin : g_no_in_reg
      assign raw_word = raw_ord;
    end
  endgenerate

  logic [65:0]            prev_q, prev_d;
  logic [65:0]            blk_q, blk_d;
  logic [6:0]             offset_q, offset_d;
  logic                   wrap_q, wrap_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [HOLD_W-1:0]      holdoff_q, holdoff_d;
  logic                   bitslip_q, bitslip_d;
  logic [131:0]           window;
  logic                   slip_accept;

  always_comb begin
    // Newest word in the upper half so a larger offset reaches later bits in time.
    window      = {raw_word, prev_q};
    prev_d      = raw_word;
    blk_d       = window[{1'b0, offset_q} +: 66];
    bitslip_d   = serdes_rx_bitslip;
    slip_accept = serdes_rx_bitslip & ~bitslip_q & (holdoff_q == '0);

    offset_d  = offset_q;
    count_d   = count_q;
    wrap_d    = 1'b0;
    holdoff_d = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : holdoff_q;

    if (slip_accept) begin
      offset_d  = (offset_q == LAST_OFFSET) ? 7'd0 : offset_q + 7'd1;
      wrap_d    = (offset_q == LAST_OFFSET);
      count_d   = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);
      holdoff_d = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      blk_q     <= '0;
      offset_q  <= '0;
      wrap_q    <= 1'b0;
      count_q   <= '0;
      holdoff_q <= '0;
      bitslip_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      blk_q     <= blk_d;
      offset_q  <= offset_d;
      wrap_q    <= wrap_d;
      count_q   <= count_d;
      holdoff_q <= holdoff_d;
      bitslip_q <= bitslip_d;
    end
  end

  assign serdes_rx_hdr  = blk_q[1:0];
  assign serdes_rx_data = blk_q[65:2];
  assign slip_offset    = offset_q;
  assign slip_wrap      = wrap_q;
  assign slip_count     = count_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_aligner.sv
// Directed bench for eth_phy_10g_rx_aligner: default instance plus a
// bit-reversed, input-registered, 4-bit-counter instance.
module tb_eth_phy_10g_rx_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [65:0] raw1, raw2;
  logic        bs1, bs2;

  logic [63:0] d1, d2;
  logic [1:0]  h1, h2;
  logic [6:0]  off1, off2;
  logic        wrap1, wrap2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_pulses;
  logic wrap_at_66;

  localparam logic [65:0] W1 = {64'h0123456789ABCDEF, 2'b01};
  localparam logic [65:0] W2 = {64'hFEDCBA9876543210, 2'b10};

  eth_phy_10g_rx_aligner u_dut1 (
    .clk               (clk),
    .rst_n             (rst_n),
    .serdes_rx_raw     (raw1),
    .serdes_rx_bitslip (bs1),
    .serdes_rx_data    (d1),
    .serdes_rx_hdr     (h1),
    .slip_offset       (off1),
    .slip_wrap         (wrap1),
    .slip_count        (cnt1)
  );

  eth_phy_10g_rx_aligner #(
    .BIT_REVERSE  (1'b1),
    .INPUT_REG    (1'b1),
    .SLIP_HOLDOFF (1),
    .COUNT_WIDTH  (4)
  ) u_dut2 (
    .clk               (clk),
    .rst_n             (rst_n),
    .serdes_rx_raw     (raw2),
    .serdes_rx_bitslip (bs2),
    .serdes_rx_data    (d2),
    .serdes_rx_hdr     (h2),
    .slip_offset       (off2),
    .slip_wrap         (wrap2),
    .slip_count        (cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] blk_of(input int k);
    return {64'h0123456789ABCDEF + 64'(k) * 64'h0000_0101_0001_0011, 2'b01};
  endfunction

  // Raw word k of a serial block stream whose block boundary sits at bit o.
  function automatic logic [65:0] sword(input int o, input int k);
    logic [131:0] t;
    t = {blk_of(k), blk_of(k - 1)} >> (66 - o);
    return t[65:0];
  endfunction

  function automatic logic [65:0] rev66(input logic [65:0] v);
    logic [65:0] r;
    r = '0;
    for (int i = 0; i < 66; i++) r[i] = v[65-i];
    return r;
  endfunction

  initial begin
    raw1 = '0; raw2 = '0; bs1 = 1'b0; bs2 = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_blk", {d1, h1}, 66'h0);
    chk("rst_off", off1, 0);
    chk("rst_wrap", wrap1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
    rst_n = 1'b1;

    // passthrough at offset 0: 2-cycle latency
    raw1 = W1;
    step();
    chk("pass_lat1", {d1, h1}, 66'h0);
    step();
    chk("pass_lat2", {d1, h1}, W1);
    chk("pass_hdr", h1, 2'b01);

    // single slip on a 1-bit shifted stream
    for (int k = 1; k <= 3; k++) begin raw1 = sword(1, k); step(); end
    bs1 = 1'b1; raw1 = sword(1, 4);
    step();
    chk("slip1_off", off1, 1);
    chk("slip1_cnt", cnt1, 1);
    chk("slip1_wrap", wrap1, 0);
    bs1 = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      raw1 = sword(1, k);
      step();
      chk("slip1_blk", {d1, h1}, blk_of(k - 1));
    end
    repeat (16) step();

    // level held 25 cycles gives one slip
    bs1 = 1'b1;
    step();
    chk("hold_first", off1, 2);
    repeat (24) step();
    bs1 = 1'b0;
    step();
    chk("hold_one_off", off1, 2);
    chk("hold_one_cnt", cnt1, 2);

    // edge at +5 discarded, edge at +20 accepted
    bs1 = 1'b1;
    step();
    chk("ho_accept", off1, 3);
    bs1 = 1'b0;
    repeat (4) step();
    bs1 = 1'b1;
    step();
    chk("ho_ignore_off", off1, 3);
    chk("ho_ignore_cnt", cnt1, 3);
    bs1 = 1'b0;
    repeat (14) step();
    bs1 = 1'b1;
    step();
    chk("ho_plus20_off", off1, 4);
    chk("ho_plus20_cnt", cnt1, 4);
    bs1 = 1'b0;

    // alignment at offset 4
    raw1 = sword(4, 10);
    step();
    for (int k = 11; k <= 14; k++) begin
      raw1 = sword(4, k);
      step();
      chk("off4_blk", {d1, h1}, blk_of(k - 1));
    end

    // mid-stream async reset while holdoff is running
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_blk", {d1, h1}, 66'h0);
    chk("mrst_off", off1, 0);
    chk("mrst_cnt", cnt1, 0);
    chk("mrst_wrap", wrap1, 0);
    step();
    rst_n = 1'b1;
    bs1 = 1'b1;
    step();
    chk("mrst_slip_off", off1, 1);
    chk("mrst_slip_cnt", cnt1, 1);
    bs1 = 1'b0;

    // wrap after 66 slips from offset 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wrap_pulses = 0;
    wrap_at_66 = 1'b0;
    for (int i = 1; i <= 66; i++) begin
      bs1 = 1'b1;
      step();
      if (wrap1) wrap_pulses++;
      if (i == 65) chk("wrap_off65", off1, 65);
      if (i == 66) wrap_at_66 = wrap1;
      bs1 = 1'b0;
      repeat (16) begin
        step();
        if (wrap1) wrap_pulses++;
      end
    end
    chk("wrap_at_66", wrap_at_66, 1);
    chk("wrap_pulses", wrap_pulses, 1);
    chk("wrap_off", off1, 0);
    chk("wrap_cnt", cnt1, 66);

    // reversed + registered input: 3-cycle latency
    raw2 = rev66(W1);
    step();
    step();
    chk("rev_lat2", {d2, h2}, 66'h0);
    step();
    chk("rev_lat3", {d2, h2}, W1);
    raw2 = rev66(W2);
    repeat (3) step();
    chk("rev_w2", {d2, h2}, W2);

    // 4-bit slip counter saturation
    for (int i = 1; i <= 20; i++) begin
      bs2 = 1'b1;
      step();
      bs2 = 1'b0;
      step();
      if (i == 15) chk("sat_cnt15", cnt2, 15);
    end
    chk("sat_cnt20", cnt2, 15);
    chk("sat_off20", off2, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
